bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 19 +
 rtl/grant_timer.sv | 30 +++
 rtl/bus_arbiter.sv | 98 +++++++++
 tb/tb_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master peripheral bus: arbiter state
// encoding, bus widths and the peripheral address map.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Peripheral base addresses on the shared bus
    localparam logic [ADDR_W-1:0] LED_BASE   = 8'hC0;
    localparam logic [ADDR_W-1:0] SW_BASE    = 8'hC1;
    localparam logic [ADDR_W-1:0] MOUSE_BASE = 8'hD0;

endpackage

// File: rtl/grant_timer.sv
// Hold counter for the current bus owner: counts grant cycles from zero,
// saturates at TIMEOUT and flags when the hold limit has been reached.
module grant_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRED
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge CLK) begin
        if (RESET || CLR) begin
            cnt <= '0;
        end else if (EN && (cnt != CNT_W'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Also true once saturated, so a master that starts requesting late
    // still gets the bus instead of waiting forever.
    assign EXPIRED = (cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: fair alternation under contention, hold-time
// preemption, an IDLE turnaround cycle on every handover, shared bus mux.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              M0_REQ,
    input  logic              M1_REQ,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic              M0_WE,
    input  logic              M1_WE,
    input  logic [DATA_W-1:0] M0_WDATA,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M0_GNT,
    output logic              M1_GNT,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WE,
    inout  wire  [DATA_W-1:0] BUS_DATA
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last;       // 1: master 1 was served most recently
    logic              expired;
    logic              drive_en;
    logic [DATA_W-1:0] drive_data;

    grant_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLR     (state == IDLE),
        .EN      (state != IDLE),
        .EXPIRED (expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT0) last <= 1'b0;
            if (state == IDLE && state_nxt == GNT1) last <= 1'b1;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value held and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (M0_REQ && M1_REQ) state_nxt = last ? GNT0 : GNT1;
                else if (M0_REQ)      state_nxt = GNT0;
                else if (M1_REQ)      state_nxt = GNT1;
            end
            GNT0: begin
                if (!M0_REQ || (expired && M1_REQ)) state_nxt = IDLE;
            end
            GNT1: begin
                if (!M1_REQ || (expired && M0_REQ)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign M0_GNT = (state == GNT0);
    assign M1_GNT = (state == GNT1);

    always_comb begin
        BUS_ADDR   = '0;
        BUS_WE     = 1'b0;
        drive_en   = 1'b0;
        drive_data = '0;
        if (M0_GNT) begin
            BUS_ADDR   = M0_ADDR;
            BUS_WE     = M0_WE;
            drive_en   = M0_WE;
            drive_data = M0_WDATA;
        end else if (M1_GNT) begin
            BUS_ADDR   = M1_ADDR;
            BUS_WE     = M1_WE;
            drive_en   = M1_WE;
            drive_data = M1_WDATA;
        end
    end

    assign BUS_DATA = drive_en ? drive_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for single-cycle behaviour
// plus hand-written timeout and long-hold sequences.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       M0_REQ, M1_REQ;
    logic [7:0] M0_ADDR, M1_ADDR;
    logic       M0_WE, M1_WE;
    logic [7:0] M0_WDATA, M1_WDATA;
    logic       M0_GNT, M1_GNT;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    wire  [7:0] BUS_DATA;

    int total = 0;
    int bad   = 0;

    // Released bus reads back as 8'hFF
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (BUS_DATA[i]);
    end

    bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .M0_REQ   (M0_REQ),
        .M1_REQ   (M1_REQ),
        .M0_ADDR  (M0_ADDR),
        .M1_ADDR  (M1_ADDR),
        .M0_WE    (M0_WE),
        .M1_WE    (M1_WE),
        .M0_WDATA (M0_WDATA),
        .M1_WDATA (M1_WDATA),
        .M0_GNT   (M0_GNT),
        .M1_GNT   (M1_GNT),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE),
        .BUS_DATA (BUS_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       r0, r1;
        logic [7:0] a0; logic w0; logic [7:0] d0;
        logic [7:0] a1; logic w1; logic [7:0] d1;
        logic       g0, g1;
        logic [7:0] ea; logic ewe; logic [7:0] ed;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input vec_t v);
        RESET    = v.rst;
        M0_REQ   = v.r0;  M1_REQ   = v.r1;
        M0_ADDR  = v.a0;  M0_WE    = v.w0;  M0_WDATA = v.d0;
        M1_ADDR  = v.a1;  M1_WE    = v.w1;  M1_WDATA = v.d1;
    endtask

    task automatic check_outputs(input string tag, input logic g0, input logic g1,
                                 input logic [7:0] ea, input logic ewe, input logic [7:0] ed);
        check({tag, ".m0_gnt"},   32'(M0_GNT),   32'(g0));
        check({tag, ".m1_gnt"},   32'(M1_GNT),   32'(g1));
        check({tag, ".bus_addr"}, 32'(BUS_ADDR), 32'(ea));
        check({tag, ".bus_we"},   32'(BUS_WE),   32'(ewe));
        check({tag, ".bus_data"}, 32'(BUS_DATA), 32'(ed));
    endtask

    initial begin
        int   n;
        logic held;

        //           rst r0 r1 a0     w0 d0     a1     w1 d1      g0 g1 ea     we data
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 8'h00, 0, 8'hFF};
        vecs[1]  = '{0, 1, 0, 8'hC0, 1, 8'hA5, 8'h00, 0, 8'h00,  1, 0, 8'hC0, 1, 8'hA5};
        vecs[2]  = '{0, 1, 0, 8'hC1, 0, 8'hA5, 8'h55, 1, 8'h77,  1, 0, 8'hC1, 0, 8'hFF};
        vecs[3]  = '{0, 1, 0, 8'hC1, 0, 8'hA5, 8'hAA, 0, 8'h77,  1, 0, 8'hC1, 0, 8'hFF};
        vecs[4]  = '{0, 0, 0, 8'hC1, 0, 8'hA5, 8'hAA, 1, 8'h77,  0, 0, 8'h00, 0, 8'hFF};
        vecs[5]  = '{0, 0, 1, 8'h12, 1, 8'h99, 8'hD0, 1, 8'h3C,  0, 1, 8'hD0, 1, 8'h3C};
        vecs[6]  = '{0, 0, 0, 8'h12, 1, 8'h99, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[7]  = '{0, 1, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  1, 0, 8'hC0, 1, 8'hA5};
        vecs[8]  = '{0, 0, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[9]  = '{0, 0, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 1, 8'hD0, 1, 8'h3C};
        vecs[10] = '{0, 1, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 1, 8'hD0, 1, 8'h3C};
        vecs[11] = '{0, 1, 0, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[12] = '{0, 1, 0, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  1, 0, 8'hC0, 1, 8'hA5};
        vecs[13] = '{0, 0, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[14] = '{0, 1, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 1, 8'hD0, 1, 8'h3C};
        vecs[15] = '{1, 1, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[16] = '{0, 1, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  1, 0, 8'hC0, 1, 8'hA5};
        vecs[17] = '{0, 0, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 0, 8'h00, 0, 8'hFF};
        vecs[18] = '{0, 0, 1, 8'hC0, 1, 8'hA5, 8'hD0, 1, 8'h3C,  0, 1, 8'hD0, 1, 8'h3C};

        apply(vecs[0]);
        for (int i = 0; i < 19; i++) begin
            apply(vecs[i]);
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1,
                          vecs[i].ea, vecs[i].ewe, vecs[i].ed);
        end

        // Timeout preemption: M0 holds, M1 arrives in grant cycle 3
        apply(vecs[0]);
        step();
        RESET = 1'b0; M0_REQ = 1'b1; M0_ADDR = LED_BASE; M0_WE = 1'b0;
        M1_ADDR = MOUSE_BASE; M1_WE = 1'b1; M1_WDATA = 8'h3C;
        step();
        n = 0;
        for (int c = 0; c < 40 && M0_GNT; c++) begin
            n++;
            if (n == 3) M1_REQ = 1'b1;
            step();
        end
        check("timeout.hold_cycles", 32'(n), 32'd16);
        check_outputs("timeout.turnaround", 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
        step();
        check_outputs("timeout.m1_grant", 1'b0, 1'b1, MOUSE_BASE, 1'b1, 8'h3C);
        M1_REQ = 1'b0;
        step();
        check_outputs("timeout.m1_release", 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
        step();
        check_outputs("timeout.m0_regrant", 1'b1, 1'b0, LED_BASE, 1'b0, 8'hFF);

        // Lone M1 holds the bus for 100 cycles with no preemption
        apply(vecs[0]);
        step();
        RESET = 1'b0; M1_REQ = 1'b1; M1_ADDR = SW_BASE; M1_WE = 1'b0;
        step();
        held = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (!(M1_GNT && !M0_GNT)) held = 1'b0;
            step();
        end
        check("longhold.m1_held", 32'(held), 32'd1);
        check("longhold.cnt_sat", 32'(dut.u_timer.cnt), 32'd16);
        check("longhold.bus_addr", 32'(BUS_ADDR), 32'(SW_BASE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
